in_fm_tile_reader: RTL and testbench

Upstream stage of `in_fm_filter`. It walks one input-feature-map tile in (channel, row, column) order, issues word read requests to external memory, and forwards the returned words in order as the `fifo_push_tmp`/`data_to_fifo_tmp` stream. The stream is exactly Tm × Tr × (Tc + TILE_ROW_OFFSET) words per tile, matching the filter's counter. Out-of-range words are still requested; the filter zeroes or drops them.

---
 rtl/in_fm_tile_reader_if.sv | 40 ++++
 rtl/in_fm_tile_reader.sv | 209 ++++++++++++++++++++
 tb/tb_in_fm_tile_reader.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/in_fm_tile_reader_if.sv
// Read-request / read-return / stream bundle between the tile reader, memory and the filter FIFO.
// Latency: n/a (wires only).
// Backpressure: rd_ready throttles requests; fifo_almost_full throttles new requests.
interface in_fm_tile_reader_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          fifo_almost_full;
    logic          fifo_push_tmp;
    logic [DW-1:0] data_to_fifo_tmp;

    // Reader side: issues requests, forwards returned words.
    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ready,
        input  rd_valid,
        input  rd_data,
        input  fifo_almost_full,
        output fifo_push_tmp,
        output data_to_fifo_tmp
    );

    // Memory / FIFO side.
    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ready,
        output rd_valid,
        output rd_data,
        output fifo_almost_full,
        input  fifo_push_tmp,
        input  data_to_fifo_tmp
    );
endinterface

// File: rtl/in_fm_tile_reader.sv
// Walks one input-feature-map tile (channel, row, column) issuing word reads; forwards returns in order.
// Latency: start -> first rd_req 1 cycle; rd_valid -> fifo_push_tmp 1 cycle; done 1 cycle after last push.
// Backpressure: no new request while MAX_OUTSTANDING in flight or fifo_almost_full; presented request held.
// Option: define IN_FM_READER_ADDR_CLAMP_EN to clamp coordinates to the feature map before addressing.
module in_fm_tile_reader #(
    parameter int AW              = 16,
    parameter int CW              = 16,
    parameter int DW              = 32,
    parameter int M               = 32,
    parameter int R               = 64,
    parameter int C               = 32,
    parameter int Tm              = 16,
    parameter int Tr              = 64,
    parameter int Tc              = 16,
    parameter int TILE_ROW_OFFSET = 2,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [AW-1:0]             base_addr,
    input  logic [CW-1:0]             tile_base_m,
    input  logic [CW-1:0]             tile_base_row,
    input  logic [CW-1:0]             tile_base_col,
    in_fm_tile_reader_if.master       bus,
    output logic                      busy,
    output logic                      done
);

    // Words fetched per tile row, including the extra halo words.
    localparam int TCW = Tc + TILE_ROW_OFFSET;
    // Width of the in-flight counter; must hold MAX_OUTSTANDING itself.
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    // Address arithmetic width: at least 2*AW, and wide enough for a coordinate sum.
    localparam int XW  = (2 * AW > CW + 1) ? 2 * AW : CW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] base;
    logic [CW-1:0] bm;
    logic [CW-1:0] br;
    logic [CW-1:0] bc;
    // Coordinates of the request currently presented (or next to be presented when stalled).
    logic [CW-1:0] tc;
    logic [CW-1:0] tr;
    logic [CW-1:0] tm;
    logic [OW-1:0] outstanding;

    logic          accept;
    logic          ret;
    logic [OW-1:0] out_nxt;
    logic          stall_nxt;
    logic          last_req;
    logic          tc_wrap;
    logic          tr_wrap;
    logic [CW-1:0] nxt_tc;
    logic [CW-1:0] nxt_tr;
    logic [CW-1:0] nxt_tm;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] nxt_addr;

    // Linear word address of a feature-map coordinate; result wraps mod 2^AW.
    function automatic logic [AW-1:0] gen_addr(
        input logic [AW-1:0] b,
        input logic [CW:0]   m,
        input logic [CW:0]   r,
        input logic [CW:0]   c
    );
        logic [XW-1:0] fm;
        logic [XW-1:0] fr;
        logic [XW-1:0] fc;
        logic [XW-1:0] lin;
        fm = XW'(m);
        fr = XW'(r);
        fc = XW'(c);
`ifdef IN_FM_READER_ADDR_CLAMP_EN
        if (fm > XW'(M - 1)) fm = XW'(M - 1);
        if (fr > XW'(R - 1)) fr = XW'(R - 1);
        if (fc > XW'(C - 1)) fc = XW'(C - 1);
`endif
        lin = (fm * XW'(R) + fr) * XW'(C) + fc;
        return b + lin[AW-1:0];
    endfunction

    // Handshake decode, in-flight bookkeeping and next-coordinate/next-address generation.
    always_comb begin
        accept    = bus.rd_req && bus.rd_ready;
        // A return with nothing in flight is stale (e.g. from before a reset) and is dropped.
        ret       = bus.rd_valid && (outstanding != '0);
        out_nxt   = outstanding;
        unique case ({accept, ret})
            2'b10:   out_nxt = outstanding + OW'(1);
            2'b01:   out_nxt = outstanding - OW'(1);
            default: out_nxt = outstanding;
        endcase
        stall_nxt = (out_nxt >= OW'(MAX_OUTSTANDING)) || bus.fifo_almost_full;

        tc_wrap   = (tc == CW'(TCW - 1));
        tr_wrap   = (tr == CW'(Tr - 1));
        last_req  = tc_wrap && tr_wrap && (tm == CW'(Tm - 1));
        nxt_tc    = tc_wrap ? '0 : tc + CW'(1);
        nxt_tr    = tc_wrap ? (tr_wrap ? '0 : tr + CW'(1)) : tr;
        nxt_tm    = (tc_wrap && tr_wrap) ? tm + CW'(1) : tm;

        first_addr = gen_addr(base_addr, {1'b0, tile_base_m}, {1'b0, tile_base_row},
                              {1'b0, tile_base_col});
        cur_addr   = gen_addr(base, {1'b0, bm} + {1'b0, tm}, {1'b0, br} + {1'b0, tr},
                              {1'b0, bc} + {1'b0, tc});
        nxt_addr   = gen_addr(base, {1'b0, bm} + {1'b0, nxt_tm}, {1'b0, br} + {1'b0, nxt_tr},
                              {1'b0, bc} + {1'b0, nxt_tc});
    end

    // Count accepted-but-unreturned requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            outstanding <= out_nxt;
        end
    end

    // Return path: one-cycle registered pass-through, no reordering or buffering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fifo_push_tmp    <= 1'b0;
            bus.data_to_fifo_tmp <= '0;
        end else begin
            bus.fifo_push_tmp    <= ret;
            bus.data_to_fifo_tmp <= bus.rd_data;
        end
    end

    // Tile sequencer: latches the origin, walks coordinates on accepts, drains, pulses done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            bus.rd_req  <= 1'b0;
            bus.rd_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            base        <= '0;
            bm          <= '0;
            br          <= '0;
            bc          <= '0;
            tc          <= '0;
            tr          <= '0;
            tm          <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ISSUE;
                        busy  <= 1'b1;
                        base  <= base_addr;
                        bm    <= tile_base_m;
                        br    <= tile_base_row;
                        bc    <= tile_base_col;
                        tc    <= '0;
                        tr    <= '0;
                        tm    <= '0;
                        if (!stall_nxt) begin
                            bus.rd_req  <= 1'b1;
                            bus.rd_addr <= first_addr;
                        end
                    end
                end
                S_ISSUE: begin
                    if (accept) begin
                        if (last_req) begin
                            bus.rd_req <= 1'b0;
                            state      <= S_DRAIN;
                        end else begin
                            tc <= nxt_tc;
                            tr <= nxt_tr;
                            tm <= nxt_tm;
                            // Back-to-back issue when not stalled keeps one request per cycle.
                            bus.rd_req <= !stall_nxt;
                            if (!stall_nxt) bus.rd_addr <= nxt_addr;
                        end
                    end else if (!bus.rd_req && !stall_nxt) begin
                        bus.rd_req  <= 1'b1;
                        bus.rd_addr <= cur_addr;
                    end
                end
                S_DRAIN: begin
                    // outstanding==0 here means the final word is already on fifo_push_tmp.
                    if (outstanding == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_in_fm_tile_reader.sv
// Bench for in_fm_tile_reader: random memory/FIFO behaviour against a coordinate-loop reference model.
// Latency: checks 1-cycle start->request, 1-cycle return->push, done after the last push.
// Backpressure: exercises rd_ready, fifo_almost_full stalls and the in-flight limit.
module tb_in_fm_tile_reader;

    localparam int AW   = 16;
    localparam int CW   = 16;
    localparam int DW   = 32;
    localparam int M    = 8;
    localparam int R    = 8;
    localparam int C    = 8;
    localparam int TM   = 2;
    localparam int TR   = 2;
    localparam int TC   = 4;
    localparam int OFF  = 2;
    localparam int MAXO = 4;
    localparam int NW   = TM * TR * (TC + OFF);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] tile_base_m;
    logic [CW-1:0] tile_base_row;
    logic [CW-1:0] tile_base_col;
    logic          busy;
    logic          done;

    in_fm_tile_reader_if #(.AW(AW), .DW(DW)) bus ();

    in_fm_tile_reader #(
        .AW(AW), .CW(CW), .DW(DW), .M(M), .R(R), .C(C),
        .Tm(TM), .Tr(TR), .Tc(TC), .TILE_ROW_OFFSET(OFF), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .tile_base_m   (tile_base_m),
        .tile_base_row (tile_base_row),
        .tile_base_col (tile_base_col),
        .bus           (bus),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Controls written by the main sequence only.
    int ready_pct   = 100;
    int resp_pct    = 100;
    int ready_limit = 32'h7fff_ffff;
    int release_req = 0;
    int late_req    = 0;
    bit hold        = 1'b0;
    bit afull       = 1'b0;

    // State written by the memory/monitor process only.
    int accept_cnt  = 0;
    int push_cnt    = 0;
    int done_cnt    = 0;
    int released    = 0;
    int late_done   = 0;
    logic [AW-1:0] pending[$];

    // Reference expectations for the current tile.
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int a0, p0, d0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return {a ^ 16'hC3A5, a};
    endfunction

    // Word address of feature-map element (fm, fr, fc) as plain arithmetic.
    function automatic logic [AW-1:0] model_addr(input int b, input int fm, input int fr, input int fc);
        longint lin;
`ifdef IN_FM_READER_ADDR_CLAMP_EN
        if (fm > M - 1) fm = M - 1;
        if (fr > R - 1) fr = R - 1;
        if (fc > C - 1) fc = C - 1;
`endif
        lin = longint'(b) + (longint'(fm) * R + fr) * C + fc;
        return AW'(lin % 65536);
    endfunction

    task automatic build_model(input int b, input int m0, input int r0, input int c0);
        logic [AW-1:0] a;
        exp_addr.delete();
        exp_data.delete();
        for (int m = 0; m < TM; m++)
            for (int r = 0; r < TR; r++)
                for (int c = 0; c < TC + OFF; c++) begin
                    a = model_addr(b, m0 + m, r0 + r, c0 + c);
                    exp_addr.push_back(a);
                    exp_data.push_back(mem_fn(a));
                end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input int b, input int m0, input int r0, input int c0);
        build_model(b, m0, r0, c0);
        a0 = accept_cnt;
        p0 = push_cnt;
        d0 = done_cnt;
        base_addr     = AW'(b);
        tile_base_m   = CW'(m0);
        tile_base_row = CW'(r0);
        tile_base_col = CW'(c0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("first_req", bus.rd_req, 1);
        chk("busy_rise", busy, 1);
    endtask

    task automatic finish_tile(input int stall_at, input int restart_at);
        bit stalled   = 1'b0;
        bit restarted = 1'b0;
        int stall_cyc = 0;
        int snap      = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            start = 1'b0;
            if (stall_at >= 0 && !stalled && accept_cnt - a0 >= stall_at) begin
                afull   = 1'b1;
                stalled = 1'b1;
            end else if (stalled && afull) begin
                stall_cyc++;
                if (stall_cyc == 2) snap = accept_cnt;
                if (stall_cyc == 10) begin
                    chk("stall_no_accept", accept_cnt, snap);
                    afull = 1'b0;
                end
            end
            if (restart_at >= 0 && !restarted && accept_cnt - a0 >= restart_at) begin
                tile_base_m   = 16'd5;
                tile_base_row = 16'd3;
                tile_base_col = 16'd1;
                start         = 1'b1;
                restarted     = 1'b1;
            end
            if (done_cnt - d0 >= 1) break;
        end
        start = 1'b0;
        afull = 1'b0;
        chk("done_seen", done_cnt - d0, 1);
        step();
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        repeat (3) step();
        chk("accepts", accept_cnt - a0, NW);
        chk("pushes", push_cnt - p0, NW);
        chk("done_once", done_cnt - d0, 1);
        chk("exp_left", exp_addr.size() + exp_data.size(), 0);
    endtask

    // Memory responder and stream monitor, acting on the falling edge.
    initial begin : mem_mon
        bit            prev_held = 1'b0;
        logic [AW-1:0] held_addr = '0;
        logic          rv;
        logic [DW-1:0] rdat;
        logic          rdy;
        bus.rd_ready         = 1'b0;
        bus.rd_valid         = 1'b0;
        bus.rd_data          = '0;
        bus.fifo_almost_full = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending.delete();
                bus.rd_ready = 1'b0;
                bus.rd_valid = 1'b0;
                prev_held    = 1'b0;
                continue;
            end
            if (bus.fifo_push_tmp) begin
                push_cnt++;
                if (exp_data.size() == 0) chk("push_extra", 1, 0);
                else chk("push_data", bus.data_to_fifo_tmp, exp_data.pop_front());
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 1);
            end
            if (prev_held)
                chk("req_held", {bus.rd_req, bus.rd_addr}, {1'b1, held_addr});
            else if (bus.rd_req)
                chk("issue_allowed", (!bus.fifo_almost_full) && (pending.size() < MAXO), 1);

            rv   = 1'b0;
            rdat = '0;
            if (late_done < late_req) begin
                rv   = 1'b1;
                rdat = 32'hDEAD_BEEF;
                late_done++;
            end else if (pending.size() > 0) begin
                if (hold ? (released < release_req) : ($urandom_range(0, 99) < resp_pct)) begin
                    rv   = 1'b1;
                    rdat = mem_fn(pending.pop_front());
                    if (hold) released++;
                end
            end
            bus.rd_valid         = rv;
            bus.rd_data          = rdat;
            bus.fifo_almost_full = afull;
            rdy = (accept_cnt < ready_limit) && ($urandom_range(0, 99) < ready_pct);
            bus.rd_ready = rdy;
            prev_held    = bus.rd_req && !rdy;
            held_addr    = bus.rd_addr;
            if (bus.rd_req && rdy) begin
                accept_cnt++;
                pending.push_back(bus.rd_addr);
                if (exp_addr.size() == 0) chk("req_extra", 1, 0);
                else chk("req_addr", bus.rd_addr, exp_addr.pop_front());
            end
        end
    end

    initial begin : main
        int rel_target;
        rst           = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        tile_base_m   = '0;
        tile_base_row = '0;
        tile_base_col = '0;
        repeat (3) step();
        chk("rst_rd_req", bus.rd_req, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_push", bus.fifo_push_tmp, 0);
        chk("rst_data", bus.data_to_fifo_tmp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        step();

        // Directed tile: full-rate memory, one-cycle return.
        launch(32'h100, 0, 0, 0);
        finish_tile(-1, -1);

        // Ten-cycle FIFO stall in the middle of the tile.
        launch(32'h100, 0, 0, 0);
        finish_tile(6, -1);

        // In-flight limit with returns withheld, then a single release.
        hold = 1'b1;
        launch(32'h100, 0, 0, 0);
        repeat (20) step();
        chk("max_out_accepts", accept_cnt - a0, MAXO);
        chk("max_out_req_low", bus.rd_req, 0);
        release_req++;
        repeat (10) step();
        chk("one_more_accept", accept_cnt - a0, MAXO + 1);
        chk("req_low_again", bus.rd_req, 0);
        hold = 1'b0;
        finish_tile(-1, -1);

        // Origin column near the right edge: clamped or raw addresses.
        launch(32'h100, 0, 0, 4);
        finish_tile(-1, -1);

        // Reset with 10 accepted and 3 in flight, then stale returns.
        hold        = 1'b1;
        ready_limit = accept_cnt + 10;
        rel_target  = release_req + 7;
        release_req = rel_target;
        launch(32'h100, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            step();
            if (accept_cnt - a0 >= 10 && released >= rel_target) break;
        end
        step();
        chk("pre_reset_accepts", accept_cnt - a0, 10);
        chk("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", bus.rd_req, 0);
        chk("mid_rst_busy", busy, 0);
        exp_addr.delete();
        exp_data.delete();
        repeat (2) step();
        rst         = 1'b0;
        hold        = 1'b0;
        ready_limit = 32'h7fff_ffff;
        p0          = push_cnt;
        late_req    = late_req + 3;
        repeat (6) step();
        chk("late_no_push", push_cnt - p0, 0);
        chk("late_idle", busy, 0);
        launch(32'h100, 0, 0, 0);
        finish_tile(-1, -1);

        // Start pulsed while busy must not disturb the tile.
        ready_pct = 70;
        resp_pct  = 60;
        launch(32'h2A0, 1, 2, 3);
        finish_tile(-1, 5);

        // Random tiles: random origin (including wrap of the address), random handshakes.
        for (int t = 0; t < 4; t++) begin
            ready_pct = $urandom_range(30, 100);
            resp_pct  = $urandom_range(30, 100);
            launch($urandom_range(0, 65535), $urandom_range(0, 300), $urandom_range(0, 12),
                   $urandom_range(0, 12));
            finish_tile((t == 1) ? 9 : -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
